skipring_ctl: RTL and testbench

Rate controller for the clock-skipping ring. Two requesters ask for a clock-suppression rate (pulses removed per LEN-cycle window). The block picks one by round-robin, builds an evenly spread suppression MASK, and drives the ring's E/RST/rSEL/MASK inputs through a safe quiesce–reload–resume sequence. It then acknowledges the winner. It sits between the host/debug control logic and the skipring instance, in the iCLK domain.

---
 rtl/skipring_pkg.sv | 22 ++
 rtl/skipring_maskgen.sv | 59 +++++
 rtl/skipring_ctl.sv | 144 ++++++++++++++
 tb/tb_skipring_ctl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/skipring_pkg.sv
// Shared types for the skip-ring rate controller: FSM states, requester indices, rate-field width.
package skipring_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_GEN,
      ST_QUIESCE,
      ST_LOAD,
      ST_RESUME,
      ST_ACK
   } state_t;

   localparam int REQ_HOST = 0;
   localparam int REQ_DBG  = 1;

   // Rate fields must hold 0..LEN, hence one bit more than the index width.
   function automatic int rate_w(input int len);
      return $clog2(len) + 1;
   endfunction

endpackage

// File: rtl/skipring_maskgen.sv
// Spreads 'rate' suppressed pulses evenly over LEN slots with a first-order accumulator.
// One slot per cycle after start_i; done_o flags the last slot, mask_o holds the result until the next run.
module skipring_maskgen
   import skipring_pkg::*;
#(
   parameter int LEN = 16,
   parameter int RW  = rate_w(LEN)
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           start_i,
   input  logic [RW-1:0]  rate_i,
   output logic           done_o,
   output logic [LEN-1:0] mask_o
);

   localparam int KW = $clog2(LEN);
   localparam logic [RW:0]   LEN_A  = (RW+1)'(LEN);
   localparam logic [KW-1:0] K_LAST = KW'(LEN-1);

   logic [RW:0]     acc_q;
   logic [RW:0]     acc_d;
   logic [RW:0]     sum;
   logic            hit;
   logic [KW-1:0]   k_q;
   logic            run_q;
   logic [LEN-1:0]  mask_q;

   always_comb begin
      sum   = acc_q + {1'b0, rate_i};
      hit   = (sum >= LEN_A);
      acc_d = hit ? (sum - LEN_A) : sum;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc_q  <= '0;
         k_q    <= '0;
         run_q  <= 1'b0;
         mask_q <= '0;
      end else if (start_i) begin
         acc_q  <= '0;
         k_q    <= '0;
         run_q  <= 1'b1;
      end else if (run_q) begin
         acc_q       <= acc_d;
         mask_q[k_q] <= hit;
         k_q         <= k_q + 1'b1;
         if (k_q == K_LAST) begin
            run_q <= 1'b0;
         end
      end
   end

   // Combinational so the controller leaves GEN exactly LEN cycles after start.
   assign done_o = run_q && (k_q == K_LAST);
   assign mask_o = mask_q;

endmodule

// File: rtl/skipring_ctl.sv
// Round-robin rate controller that reprograms the skip ring via quiesce, reload and resume.
// Registered outputs; waits indefinitely on ring_oST in QUIESCE/RESUME; req is only sampled in IDLE.
module skipring_ctl
   import skipring_pkg::*;
#(
   parameter int             LEN    = 16,
   parameter logic [LEN-1:0] defSEL = {{(LEN-1){1'b0}}, 1'b1},
   parameter int             SETTLE = 2,
   parameter int             RW     = rate_w(LEN)
) (
   input  logic           iCLK,
   input  logic           RST,
   input  logic [1:0]     req,
   input  logic [RW-1:0]  rate0,
   input  logic [RW-1:0]  rate1,
   output logic [1:0]     gnt,
   output logic           busy,
   output logic [RW-1:0]  cur_rate,
   output logic           ring_E,
   output logic           ring_RST,
   output logic [LEN-1:0] ring_rSEL,
   output logic [LEN-1:0] ring_MASK,
   input  logic           ring_oST
);

   localparam int            SW     = $clog2(SETTLE + 1);
   localparam logic [SW-1:0] S_LAST = SW'(SETTLE - 1);
   localparam logic [RW-1:0] LEN_R  = RW'(LEN);

   state_t          state_q;
   logic [1:0]      req_q;
   logic            win_q;
   logic            win_d;
   logic            rr_q;
   logic [RW-1:0]   raw_rate;
   logic [RW-1:0]   rate_d;
   logic [RW-1:0]   lat_rate_q;
   logic [RW-1:0]   cur_rate_q;
   logic [SW-1:0]   settle_q;
   logic [1:0]      gnt_q;
   logic            e_q;
   logic            rst_q;
   logic [LEN-1:0]  rsel_q;
   logic [LEN-1:0]  mask_q;
   logic            mg_start;
   logic            mg_done;
   logic [LEN-1:0]  mg_mask;

   // rr_q holds the last grantee, so a tie goes to the other requester.
   always_comb begin
      win_d    = (req_q == 2'b11) ? ~rr_q : req_q[REQ_DBG];
      raw_rate = win_d ? rate1 : rate0;
      rate_d   = (raw_rate >= LEN_R) ? (LEN_R - 1'b1) : raw_rate;
      mg_start = (state_q == ST_ARB) && (rate_d != cur_rate_q);
   end

   skipring_maskgen #(
      .LEN (LEN),
      .RW  (RW)
   ) u_maskgen (
      .clk_i   (iCLK),
      .rst_i   (RST),
      .start_i (mg_start),
      .rate_i  (lat_rate_q),
      .done_o  (mg_done),
      .mask_o  (mg_mask)
   );

   always_ff @(posedge iCLK) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         req_q      <= '0;
         win_q      <= 1'b0;
         rr_q       <= 1'b1;
         lat_rate_q <= '0;
         cur_rate_q <= '0;
         settle_q   <= '0;
         gnt_q      <= '0;
         e_q        <= 1'b1;
         rst_q      <= 1'b0;
         rsel_q     <= defSEL;
         mask_q     <= '0;
      end else begin
         gnt_q <= '0;
         case (state_q)
            ST_IDLE: begin
               if (|req) begin
                  req_q   <= req;
                  state_q <= ST_ARB;
               end
            end
            ST_ARB: begin
               win_q      <= win_d;
               lat_rate_q <= rate_d;
               state_q    <= (rate_d == cur_rate_q) ? ST_ACK : ST_GEN;
            end
            ST_GEN: begin
               if (mg_done) begin
                  e_q      <= 1'b0;
                  settle_q <= '0;
                  state_q  <= ST_QUIESCE;
               end
            end
            ST_QUIESCE: begin
               if (settle_q != S_LAST) begin
                  settle_q <= settle_q + 1'b1;
               end else if (!ring_oST) begin
                  rst_q      <= 1'b1;
                  rsel_q     <= defSEL;
                  mask_q     <= mg_mask;
                  cur_rate_q <= lat_rate_q;
                  state_q    <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               rst_q   <= 1'b0;
               e_q     <= 1'b1;
               state_q <= ST_RESUME;
            end
            ST_RESUME: begin
               if (ring_oST) begin
                  state_q <= ST_ACK;
               end
            end
            ST_ACK: begin
               gnt_q[REQ_HOST] <= ~win_q;
               gnt_q[REQ_DBG]  <= win_q;
               rr_q            <= win_q;
               state_q         <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign busy      = (state_q != ST_IDLE);
   assign cur_rate  = cur_rate_q;
   assign ring_E    = e_q;
   assign ring_RST  = rst_q;
   assign ring_rSEL = rsel_q;
   assign ring_MASK = mask_q;

endmodule

// File: tb/tb_skipring_ctl.sv
// Scoreboard bench for skipring_ctl with an ideal ring whose oST tracks E combinationally.
module tb_skipring_ctl;

   localparam int LEN = 16;
   localparam int RW  = 5;

   logic           iCLK = 1'b0;
   logic           RST;
   logic [1:0]     req;
   logic [RW-1:0]  rate0;
   logic [RW-1:0]  rate1;
   logic [1:0]     gnt;
   logic           busy;
   logic [RW-1:0]  cur_rate;
   logic           ring_E;
   logic           ring_RST;
   logic [LEN-1:0] ring_rSEL;
   logic [LEN-1:0] ring_MASK;
   logic           ring_oST;
   logic           ost_hold;

   typedef struct {
      logic [1:0]     g;
      logic [LEN-1:0] mask;
      logic [RW-1:0]  rate;
   } exp_t;

   exp_t sb[$];
   int n_vec = 0;
   int n_err = 0;
   int rst_cnt, elow_cnt, rsel_bad, last_gnt_cyc, first_rst_cyc;
   int held_rst, gnt_seen, busy_seen;

   assign ring_oST = ost_hold | ring_E;

   always #5 iCLK = ~iCLK;

   skipring_ctl #(
      .LEN    (LEN),
      .SETTLE (2)
   ) dut (
      .iCLK      (iCLK),
      .RST       (RST),
      .req       (req),
      .rate0     (rate0),
      .rate1     (rate1),
      .gnt       (gnt),
      .busy      (busy),
      .cur_rate  (cur_rate),
      .ring_E    (ring_E),
      .ring_RST  (ring_RST),
      .ring_rSEL (ring_rSEL),
      .ring_MASK (ring_MASK),
      .ring_oST  (ring_oST)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input int idx, input logic [LEN-1:0] m, input logic [RW-1:0] r);
      exp_t e;
      e.g    = (idx == 1) ? 2'b10 : 2'b01;
      e.mask = m;
      e.rate = r;
      sb.push_back(e);
   endtask

   function automatic bit pending(input int i);
      foreach (sb[j]) begin
         if (sb[j].g[i]) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Runs until all requests are served; drops a req bit once its last expected grant arrives.
   task automatic drain(input string tag);
      int cyc;
      cyc = 0;
      rst_cnt = 0; elow_cnt = 0; rsel_bad = 0; last_gnt_cyc = -1; first_rst_cyc = -1;
      while ((req != 2'b00 || busy || sb.size() != 0) && cyc < 300) begin
         @(negedge iCLK);
         cyc++;
         if (ring_RST) begin
            rst_cnt++;
            if (first_rst_cyc < 0) first_rst_cyc = cyc;
            if (ring_rSEL != 16'h0001) rsel_bad++;
         end
         if (!ring_E) elow_cnt++;
         if (gnt != 2'b00) begin
            if (sb.size() == 0) begin
               chk({tag, "_extra_gnt"}, 32'(gnt), 32'd0);
               req = 2'b00;
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk({tag, "_gnt"}, 32'(gnt), 32'(e.g));
               chk({tag, "_mask"}, 32'(ring_MASK), 32'(e.mask));
               chk({tag, "_cur_rate"}, 32'(cur_rate), 32'(e.rate));
               last_gnt_cyc = cyc;
               for (int i = 0; i < 2; i++) begin
                  if (gnt[i] && !pending(i)) req[i] = 1'b0;
               end
            end
         end
      end
      chk({tag, "_in_budget"}, 32'(cyc < 300), 32'd1);
      if (cyc >= 300) begin
         sb.delete();
         req = 2'b00;
      end
   endtask

   task automatic wait_quiesce(input string tag);
      int cyc;
      cyc = 0;
      while (ring_E && cyc < 100) begin
         @(negedge iCLK);
         cyc++;
      end
      chk({tag, "_quiesce_seen"}, 32'(ring_E), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      RST = 1'b1; req = 2'b00; rate0 = '0; rate1 = '0; ost_hold = 1'b0;
      repeat (3) @(negedge iCLK);
      RST = 1'b0;
      @(negedge iCLK);
      chk("rst_E", 32'(ring_E), 32'd1);
      chk("rst_RST", 32'(ring_RST), 32'd0);
      chk("rst_rSEL", 32'(ring_rSEL), 32'h0001);
      chk("rst_MASK", 32'(ring_MASK), 32'd0);
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cur_rate", 32'(cur_rate), 32'd0);

      // Host rate 4 through the full reload path.
      rate0 = 5'd4; req = 2'b01;
      push_exp(0, 16'h8888, 5'd4);
      drain("host4");
      chk("host4_latency", 32'(last_gnt_cyc), 32'd23);
      chk("host4_rst_pulses", 32'(rst_cnt), 32'd1);
      chk("host4_rsel_bad", 32'(rsel_bad), 32'd0);
      chk("host4_e_low", 32'(elow_cnt), 32'd3);

      rate1 = 5'd8; req = 2'b10;
      push_exp(1, 16'hAAAA, 5'd8);
      drain("dbg8");
      rate1 = 5'd1; req = 2'b10;
      push_exp(1, 16'h8000, 5'd1);
      drain("dbg1");
      rate1 = 5'd0; req = 2'b10;
      push_exp(1, 16'h0000, 5'd0);
      drain("dbg0");

      // Simultaneous requests: host first, then debug wins the following tie, then host again.
      rate0 = 5'd2; rate1 = 5'd3; req = 2'b11;
      push_exp(0, 16'h8080, 5'd2);
      push_exp(1, 16'h8420, 5'd3);
      push_exp(0, 16'h8080, 5'd2);
      drain("tie");

      rate0 = 5'd4; req = 2'b01;
      push_exp(0, 16'h8888, 5'd4);
      drain("set4");
      rate0 = 5'd4; req = 2'b01;
      push_exp(0, 16'h8888, 5'd4);
      drain("same4");
      chk("same4_latency", 32'(last_gnt_cyc), 32'd3);
      chk("same4_rst_pulses", 32'(rst_cnt), 32'd0);
      chk("same4_e_low", 32'(elow_cnt), 32'd0);

      rate0 = 5'd20; req = 2'b01;
      push_exp(0, 16'hFFFE, 5'd15);
      drain("clamp");

      // Reset in the middle of QUIESCE aborts without a grant.
      rate0 = 5'd4; req = 2'b01;
      wait_quiesce("abort");
      RST = 1'b1; req = 2'b00;
      @(negedge iCLK);
      RST = 1'b0;
      chk("abort_E", 32'(ring_E), 32'd1);
      chk("abort_RST", 32'(ring_RST), 32'd0);
      chk("abort_rSEL", 32'(ring_rSEL), 32'h0001);
      chk("abort_MASK", 32'(ring_MASK), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cur_rate", 32'(cur_rate), 32'd0);
      gnt_seen = 0; busy_seen = 0;
      repeat (30) begin
         @(negedge iCLK);
         if (gnt != 2'b00) gnt_seen++;
         if (busy) busy_seen++;
      end
      chk("abort_no_gnt", 32'(gnt_seen), 32'd0);
      chk("abort_idle", 32'(busy_seen), 32'd0);

      // Tie right after reset goes to host; ring holds oST high during QUIESCE.
      rate0 = 5'd4; rate1 = 5'd8; req = 2'b11;
      push_exp(0, 16'h8888, 5'd4);
      push_exp(1, 16'hAAAA, 5'd8);
      wait_quiesce("hold");
      ost_hold = 1'b1;
      held_rst = 0;
      repeat (10) begin
         @(negedge iCLK);
         if (ring_RST) held_rst++;
      end
      ost_hold = 1'b0;
      chk("hold_no_load", 32'(held_rst), 32'd0);
      chk("hold_still_busy", 32'(busy), 32'd1);
      drain("hold");
      chk("hold_load_after_release", 32'(first_rst_cyc), 32'd1);
      chk("hold_rst_pulses", 32'(rst_cnt), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
